edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel edge-event scheduler that sits behind the synchronized level inputs of the design and in front of a single shared event consumer. Detects rising edges on N_CH level lines, latches each as a pending event, and hands events one at a time to the consumer over a valid/ready handshake. Channels are served in round-robin order so no channel can starve the others. Events that arrive while the same channel is still pending are flagged as overruns.

## Interface
- N_CH, 4: number of level channels (2..16).
- CH_W, $clog2(N_CH): channel index width (derived, not overridden).

- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- level  input  N_CH  level lines, already synchronous to clk.
- ch_en  input  N_CH  per-channel enable; 0 = edges ignored, pending dropped.
- clr_overrun  input  1  one-cycle pulse, clears all overrun flags.
- evt_valid  output  1  event presented to consumer.
- evt_ready  input  1  consumer accepts event when evt_valid & evt_ready.
- evt_ch  output  CH_W  channel index of presented event.
- evt_fall  output  1  1 = falling-edge event (see Configuration).
- pending  output  N_CH  latched, not-yet-issued events.
- overrun  output  N_CH  sticky: edge arrived while that channel already pending.

## Operation
- Per channel: delay register (reset 0) samples level each clk; rise[i] = level[i] & ~delay[i].
- pending[i] set at clk edge when rise[i] & ch_en[i]; cleared when channel i is loaded into output register; cleared when ch_en[i] = 0.
- Load and new rise on same channel same cycle: pending[i] ends 1 (new event kept), no overrun.
- rise[i] while pending[i] = 1 and not being loaded: pending stays 1, overrun[i] set. clr_overrun clears all; set wins over simultaneous clear.
- Output FSM, two states: IDLE (evt_valid = 0), HOLD (evt_valid = 1).
  - IDLE: if any pending & ch_en -> load winner, go HOLD.
  - HOLD: evt_ch/evt_fall stable until accept. On accept: if another pending -> load next winner same edge, stay HOLD; else IDLE.
- Round-robin: search starts at last_grant+1, wraps at N_CH-1 -> 0; last_grant updates on each load. last_grant resets to N_CH-1, so channel 0 has first priority.
- Disabling a channel never affects an event already in the output register.

## Timing
- Reset values: evt_valid 0, evt_ch 0, evt_fall 0, pending 0, overrun 0, delay regs 0, state IDLE.
- Latency: level high first sampled at edge E0 -> pending set at E0 -> evt_valid high after E1 (one-cycle pending-to-valid).
- Throughput: one event per clk with evt_ready held 1.
- Handshake: evt_valid never drops without accept; evt_ch never changes while evt_valid & ~evt_ready.
- Reset asserted mid-handshake: outputs drop to reset values immediately (asynchronous); an in-flight event is lost.
- level high at reset release: delay reg is 0, so a rise is detected on first clk edge (intentional; consumers must tolerate it).

## Configuration
- EDGE_ARB_FALL_EN defined: each channel also detects falling edges (fall[i] = ~level[i] & delay[i]); separate pending/overrun state per edge type, arbitration over 2*N_CH sources ordered ch0-rise, ch0-fall, ch1-rise...; evt_fall reports type; pending/overrun outputs are OR of both types.
- Not defined: falling edges ignored, evt_fall tied 0.

## Structure
- Package edge_arb_pkg: FSM state enum (ST_IDLE, ST_HOLD), max-channel constant, round-robin next-index function.
- Sub-module edge_tick_cell: one channel delay register plus rise/fall decode; instantiated N_CH times via generate.

## Test plan
- Reset release, level=0000, ready=1; raise level[2] -> pending[2] at E0, evt_valid=1 evt_ch=2 after E1, pending[2]=0.
- Rise on ch0..3 same cycle, ready=1 -> evt_ch sequence 0,1,2,3 on consecutive cycles, then evt_valid=0.
- ready=0 for 5 cycles while ch1 presented -> evt_ch held 1; second ch1 rise during wait -> pending[1]=1, no overrun; third rise -> overrun[1]=1; clr_overrun -> overrun=0.
- last_grant=3, ch0 and ch3 pending together -> ch0 served before ch3 (wrap check).
- ch_en[1]=0 while pending[1]=1 -> pending[1]=0 next cycle, no ch1 event; rise with ch_en=0 ignored.
- With EDGE_ARB_FALL_EN: pulse level[0] high 1 cycle -> events (ch0, fall=0) then (ch0, fall=1).

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for edge_event_arbiter: FSM states, size limits, round-robin pick.
package edge_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_t;

  localparam int MAX_CH    = 16;
  localparam int MAX_SRC   = 2 * MAX_CH;
  localparam int SRC_IDX_W = $clog2(MAX_SRC);

  // First requesting source after 'last', wrapping at n_src-1 -> 0; 'last' itself is checked last.
  function automatic int rr_next_grant(input logic [MAX_SRC-1:0] req, input int last,
                                       input int n_src);
    int  pick;
    int  idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_SRC; k++) begin
      idx = (last + k) % n_src;
      if (!found && (k <= n_src) && req[idx[SRC_IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/edge_tick_cell.sv
// One level channel: delay register plus rise/fall decode, combinational from the current level.
module edge_tick_cell (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic delay_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) delay_q <= 1'b0;
    else        delay_q <= level;
  end

  assign rise = level & ~delay_q;
  assign fall = ~level & delay_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin edge-event scheduler; pending -> evt_valid in one cycle, one event/clk, holds under ~evt_ready.
// EDGE_ARB_FALL_EN adds falling-edge sources (ch0-rise, ch0-fall, ch1-rise, ...).
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] level,
  input  logic [N_CH-1:0] ch_en,
  input  logic            clr_overrun,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_fall,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] overrun
);

`ifdef EDGE_ARB_FALL_EN
  localparam int N_SRC = 2 * N_CH;
`else
  localparam int N_SRC = N_CH;
`endif
  localparam int SW = $clog2(N_SRC);

  logic [N_CH-1:0]  rise, fall;
  logic [N_SRC-1:0] src_edge, src_en;
  logic [N_SRC-1:0] pend_q, pend_nxt, ovr_q, ovr_nxt;
  logic [N_SRC-1:0] req, load_vec;
  logic [SW-1:0]    win_src, last_grant;
  logic             any_req, load;
  arb_state_t       state, state_nxt;

  for (genvar c = 0; c < N_CH; c++) begin : g_cell
    edge_tick_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .level(level[c]),
      .rise (rise[c]),
      .fall (fall[c])
    );
  end

`ifdef EDGE_ARB_FALL_EN
  logic fall_q;

  always_comb begin
    src_edge = '0;
    src_en   = '0;
    pending  = '0;
    overrun  = '0;
    for (int c = 0; c < N_CH; c++) begin
      src_edge[2*c]   = rise[c];
      src_edge[2*c+1] = fall[c];
      src_en[2*c]     = ch_en[c];
      src_en[2*c+1]   = ch_en[c];
      pending[c]      = pend_q[2*c] | pend_q[2*c+1];
      overrun[c]      = ovr_q[2*c] | ovr_q[2*c+1];
    end
  end

  assign evt_fall = fall_q;
`else
  logic unused_fall;

  assign src_edge    = rise;
  assign src_en      = ch_en;
  assign pending     = pend_q;
  assign overrun     = ovr_q;
  assign evt_fall    = 1'b0;
  assign unused_fall = ^fall;
`endif

  assign req      = pend_q & src_en;
  assign any_req  = |req;
  assign win_src  = SW'(rr_next_grant(MAX_SRC'(req), int'(last_grant), N_SRC));
  assign load_vec = load ? (N_SRC'(1) << win_src) : '0;

  // A fresh edge on the source being loaded re-arms it; overrun only when the old event is still waiting.
  assign pend_nxt = src_en & (src_edge | (pend_q & ~load_vec));
  assign ovr_nxt  = (ovr_q & {N_SRC{~clr_overrun}}) | (src_en & src_edge & pend_q & ~load_vec);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (evt_ready) begin
          if (any_req) load = 1'b1;
          else         state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign evt_valid = (state == ST_HOLD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pend_q     <= '0;
      ovr_q      <= '0;
      last_grant <= SW'(N_SRC - 1);
      evt_ch     <= '0;
`ifdef EDGE_ARB_FALL_EN
      fall_q     <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      ovr_q  <= ovr_nxt;
      if (load) begin
        last_grant <= win_src;
`ifdef EDGE_ARB_FALL_EN
        evt_ch     <= win_src[SW-1:1];
        fall_q     <= win_src[0];
`else
        evt_ch     <= win_src;
`endif
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed plus randomized bench for edge_event_arbiter (default build, rising edges only).
module tb_edge_event_arbiter;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] ch_en;
  logic            clr_overrun;
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic            evt_fall;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: the event in the consumer slot, per-channel flags, previous levels.
  bit              m_valid;
  int              m_ch;
  logic [N_CH-1:0] m_pend;
  logic [N_CH-1:0] m_ovr;
  logic [N_CH-1:0] m_prev;
  int              m_last;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(N_CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .level      (level),
    .ch_en      (ch_en),
    .clr_overrun(clr_overrun),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_fall   (evt_fall),
    .pending    (pending),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ch    = 0;
    m_pend  = '0;
    m_ovr   = '0;
    m_prev  = '0;
    m_last  = N_CH - 1;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] rise;
    bit accept;
    bit set_ovr;
    int loaded;
    int c;
    rise   = level & ~m_prev;
    accept = m_valid && evt_ready;
    loaded = -1;
    if (!m_valid || accept) begin
      for (int k = 1; k <= N_CH; k++) begin
        c = (m_last + k) % N_CH;
        if (loaded < 0 && m_pend[c] && ch_en[c]) loaded = c;
      end
      if (loaded >= 0) begin
        m_valid = 1'b1;
        m_ch    = loaded;
        m_last  = loaded;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      set_ovr = 1'b0;
      if (!ch_en[i]) m_pend[i] = 1'b0;
      else if (rise[i]) begin
        if (m_pend[i] && i != loaded) set_ovr = 1'b1;
        m_pend[i] = 1'b1;
      end else if (i == loaded) m_pend[i] = 1'b0;
      if (set_ovr) m_ovr[i] = 1'b1;
      else if (clr_overrun) m_ovr[i] = 1'b0;
    end
    m_prev = level;
  endtask

  task automatic check_outputs();
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_ch", 32'(evt_ch), 32'(m_ch));
    chk("evt_fall", 32'(evt_fall), 32'd0);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
    check_outputs();
  endtask

  initial begin
    reset       = 1'b0;
    level       = '1;
    ch_en       = '1;
    clr_overrun = 1'b0;
    evt_ready   = 1'b1;
    model_reset();
    cycle();
    cycle();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);

    level = '0;
    reset = 1'b1;
    cycle();
    cycle();

    // Single rise on ch2: pending at E0, presented after E1.
    level = 4'b0100;
    cycle();
    chk("t1_pend_e0", 32'(pending), 32'h4);
    chk("t1_valid_e0", 32'(evt_valid), 32'd0);
    cycle();
    chk("t1_valid_e1", 32'(evt_valid), 32'd1);
    chk("t1_ch_e1", 32'(evt_ch), 32'd2);
    chk("t1_pend_e1", 32'(pending), 32'h0);
    cycle();
    level = 4'b0000;
    cycle();

    // Make ch3 the last grant, then all four rise together.
    level = 4'b1000;
    cycle();
    cycle();
    cycle();
    level = 4'b0000;
    cycle();
    level = 4'b1111;
    cycle();
    for (int k = 0; k < N_CH; k++) begin
      cycle();
      chk("t2_seq_valid", 32'(evt_valid), 32'd1);
      chk("t2_seq_ch", 32'(evt_ch), 32'(k));
    end
    cycle();
    chk("t2_done", 32'(evt_valid), 32'd0);
    level = 4'b0000;
    cycle();

    // ch1 held under backpressure; re-rise keeps it pending, third rise overruns.
    level = 4'b0010;
    cycle();
    evt_ready = 1'b0;
    cycle();
    chk("t3_ch", 32'(evt_ch), 32'd1);
    level = 4'b0000;
    cycle();
    level = 4'b0010;
    cycle();
    chk("t3_pend", 32'(pending), 32'h2);
    chk("t3_no_ovr", 32'(overrun), 32'h0);
    level = 4'b0000;
    cycle();
    level = 4'b0010;
    cycle();
    chk("t3_ovr", 32'(overrun), 32'h2);
    cycle();
    chk("t3_hold_ch", 32'(evt_ch), 32'd1);
    chk("t3_hold_valid", 32'(evt_valid), 32'd1);
    clr_overrun = 1'b1;
    cycle();
    clr_overrun = 1'b0;
    chk("t3_clr", 32'(overrun), 32'h0);
    evt_ready = 1'b1;
    cycle();
    cycle();
    level = 4'b0000;
    cycle();

    // Wrap: last grant 3, ch0 and ch3 pending -> ch0 first.
    level = 4'b1000;
    cycle();
    evt_ready = 1'b0;
    cycle();
    level = 4'b0000;
    cycle();
    level = 4'b1001;
    cycle();
    evt_ready = 1'b1;
    cycle();
    chk("t4_first", 32'(evt_ch), 32'd0);
    cycle();
    chk("t4_second", 32'(evt_ch), 32'd3);
    cycle();
    level = 4'b0000;
    cycle();

    // Disable drops pending ch1; rise while disabled is ignored.
    level = 4'b0100;
    cycle();
    evt_ready = 1'b0;
    cycle();
    level = 4'b0110;
    cycle();
    ch_en = 4'b1101;
    cycle();
    chk("t5_drop", 32'(pending), 32'h0);
    level = 4'b0100;
    cycle();
    level = 4'b0110;
    cycle();
    chk("t5_ignored", 32'(pending), 32'h0);
    chk("t5_held_ch", 32'(evt_ch), 32'd2);
    evt_ready = 1'b1;
    ch_en     = 4'b1111;
    cycle();
    chk("t5_idle", 32'(evt_valid), 32'd0);
    level = 4'b0000;
    cycle();

    // Asynchronous reset in the middle of a handshake.
    level = 4'b0001;
    cycle();
    evt_ready = 1'b0;
    cycle();
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", 32'(evt_valid), 32'd0);
    chk("t6_async_ch", 32'(evt_ch), 32'd0);
    cycle();
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      level       = N_CH'($urandom);
      ch_en       = ($urandom_range(0, 9) == 0) ? N_CH'($urandom) : '1;
      evt_ready   = ($urandom_range(0, 3) != 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
